// File: rtl/dcache_miss_handler.sv
// Direct-mapped, one-word-per-line, write-through/no-allocate data cache front end.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_miss_handler #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic [31:0]       data_rdata,
    output logic              data_busy1,
    output logic              data_missed1,
    output logic              data_finished1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic [1:0]        dbg_state
);

    // Request handshake: a request transfers on a rising edge where
    // req_valid && req_ready; req_ready never depends on req_valid.
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_MEM    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-3:0] word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [TAG_W-1:0]  tag_d [LINES];
    logic [31:0]       line_q [LINES];
    logic [31:0]       line_d [LINES];

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              lookup_hit;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];
    assign cur_idx    = word_q[IDX_W-1:0];
    assign cur_tag    = word_q[ADDR_W-3:IDX_W];
    assign lookup_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    // Async reset drops state to IDLE at once, so every state-derived output
    // is already 0; only req_ready needs explicit gating with reset.
    assign req_ready  = (state_q == S_IDLE) && !flush && !reset;
    assign data_busy1 = (state_q != S_IDLE);
    assign mem_req    = (state_q == S_MEM);
    assign mem_we     = (state_q == S_MEM) && we_q;
    assign mem_addr   = {word_q, 2'b00};
    assign mem_wdata  = wdata_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d        = state_q;
        we_d           = we_q;
        word_d         = word_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        line_d         = line_q;
        data_missed1   = 1'b0;
        data_finished1 = 1'b0;
        data_rdata     = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (req_valid) begin
                    we_d    = req_we;
                    word_d  = req_addr[ADDR_W-1:2];
                    wdata_d = req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!we_q && lookup_hit) begin
                    data_rdata     = line_q[cur_idx];
                    data_finished1 = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    // Stores always go to memory; a store hit also refreshes the line.
                    if (we_q && lookup_hit) begin
                        line_d[cur_idx] = wdata_q;
                    end
                    data_missed1 = !lookup_hit;
                    state_d      = S_MEM;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        valid_d[cur_idx] = 1'b1;
                        tag_d[cur_idx]   = cur_tag;
                        line_d[cur_idx]  = mem_rdata;
                        rdata_d          = mem_rdata;
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                data_finished1 = 1'b1;
                data_rdata     = we_q ? 32'h0 : rdata_q;
                state_d        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == S_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Randomized bench for dcache_miss_handler: memory responder, cache/memory reference
// model, and a scoreboard monitor that checks every completion.
module tb_dcache_miss_handler;
    localparam int LINES  = 16;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              flush;
    logic [31:0]       data_rdata;
    logic              data_busy1;
    logic              data_missed1;
    logic              data_finished1;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif
    logic [1:0]        dbg_state;

    dcache_miss_handler #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .data_rdata(data_rdata), .data_busy1(data_busy1),
        .data_missed1(data_missed1), .data_finished1(data_finished1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef DCACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking infrastructure ----------------
    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // ref_mem: what each word must hold; res_word: which word each line holds.
    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] bus_mem  [int unsigned];
    int unsigned res_word [int unsigned];
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;

    function automatic logic [31:0] init_word(int unsigned w);
        return w * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] ref_read(int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    // Expected entry: {we, missed, mem_txn, rdata}
    logic [34:0] exp_q[$];

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    int                fixed_delay = -1;
    bit                hold_ack    = 1'b0;
    int                done_cnt    = 0;

    // ---------------- memory responder ----------------
    initial begin : responder
        int wait_cnt;
        int unsigned w;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wait_cnt  = -1;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (reset || hold_ack) begin
                wait_cnt = -1;
            end else if (mem_req) begin
                if (wait_cnt < 0) wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    chk("mem_addr", mem_addr, cur_addr);
                    chk("mem_we", 32'(mem_we), 32'(cur_we));
                    w = mem_addr >> 2;
                    if (mem_we) begin
                        chk("mem_wdata", mem_wdata, cur_wdata);
                        bus_mem[w] = mem_wdata;
                    end else begin
                        mem_rdata = bus_mem.exists(w) ? bus_mem[w] : init_word(w);
                    end
                    mem_ack  = 1'b1;
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                // Stray acknowledges outside a memory transaction must be ignored.
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        int  cyc_n, acc_cyc, txns;
        bit  seen_miss, prev_mreq;
        logic [34:0] e;
        cyc_n = 0; acc_cyc = 0; txns = 0; seen_miss = 0; prev_mreq = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen_miss = 0; txns = 0; prev_mreq = 0;
            end else begin
                cyc_n++;
                if (req_valid && req_ready) acc_cyc = cyc_n;
                if (mem_req && !prev_mreq) txns++;
                prev_mreq = mem_req;
                if (data_missed1 && data_finished1)
                    chk("missed_and_finished_together", 32'd1, 32'd0);
                if (data_missed1) seen_miss = 1;
                if (data_finished1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_finish", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_rdata", data_rdata, e[31:0]);
                        chk("missed_pulse", 32'(seen_miss), 32'(e[33]));
                        chk("mem_txn_count", 32'(txns), 32'(e[32]));
                        if (!e[34] && !e[33]) chk("hit_latency", 32'(cyc_n - acc_cyc), 32'd1);
                        else chk("miss_latency_ge3", 32'(cyc_n - acc_cyc >= 3), 32'd1);
                    end
                    done_cnt++;
                    seen_miss = 0;
                    txns = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd, input bit wait_done);
        int unsigned w, idx;
        bit hit;
        int start, n;
        w   = addr >> 2;
        idx = w % LINES;
        hit = res_word.exists(idx) && (res_word[idx] == w);
        if (hit) m_hits++; else m_misses++;
        if (we) begin
            ref_mem[w] = wd;
            exp_q.push_back({1'b1, !hit, 1'b1, 32'h0});
        end else begin
            exp_q.push_back({1'b0, !hit, !hit, ref_read(w)});
            if (!hit) res_word[idx] = w;
        end
        cur_we    = we;
        cur_addr  = {addr[ADDR_W-1:2], 2'b00};
        cur_wdata = wd;
        start     = done_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("req_ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (wait_done) begin
            n = 0;
            while (done_cnt == start && n < 100) begin
                @(posedge clk);
                n++;
            end
            if (n >= 100) chk("completion_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic do_flush(input bit with_req);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        req_valid = with_req;
        req_we    = 1'b0;
        req_addr  = 32'h100;
        #1;
        chk("flush_blocks_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        res_word.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_busy"}, 32'(data_busy1), 32'd0);
        chk({tag, "_missed"}, 32'(data_missed1), 32'd0);
        chk({tag, "_finished"}, 32'(data_finished1), 32'd0);
        chk({tag, "_rdata"}, data_rdata, 32'h0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hit_count"}, hit_count, 32'd0);
        chk({tag, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin : main
        int n;
        logic [ADDR_W-1:0] a;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        flush     = 1'b0;
        bus_mem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Cold load, memory answers two cycles after the request appears
        fixed_delay = 2;
        do_req(1'b0, 32'h100, 32'h0, 1'b1);
        do_req(1'b0, 32'h100, 32'h0, 1'b1);
        do_req(1'b1, 32'h100, 32'h1234_5678, 1'b1);
        do_req(1'b0, 32'h100, 32'h0, 1'b1);

        // Conflicting tags on one index, with the fastest memory answer
        fixed_delay = 0;
        do_req(1'b0, 32'h140, 32'h0, 1'b1);
        do_req(1'b0, 32'h100, 32'h0, 1'b1);

        do_flush(1'b1);
        do_req(1'b0, 32'h140, 32'h0, 1'b1);
        do_req(1'b0, 32'h140, 32'h0, 1'b1);

        // Random mix; upper address bits vary so tag comparison matters
        fixed_delay = -1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush($urandom_range(0, 1));
            end else begin
                a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                a = a | (ADDR_W'($urandom_range(0, 1)) << 20);
                do_req($urandom_range(0, 2) == 0, a, $urandom, 1'b1);
            end
        end
`ifdef DCACHE_STATS_EN
        #1;
        chk("hit_count_total", hit_count, m_hits);
        chk("miss_count_total", miss_count, m_misses);
`endif

        // Reset while a memory read is outstanding
        do_flush(1'b0);
        hold_ack = 1'b1;
        do_req(1'b0, 32'h100, 32'h0, 1'b0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_mem_before_reset", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_mem_reset");
        exp_q.delete();
        res_word.delete();
        m_hits   = 0;
        m_misses = 0;
        hold_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        do_req(1'b0, 32'h100, 32'h0, 1'b1);
        do_req(1'b0, 32'h100, 32'h0, 1'b1);

        repeat (3) @(posedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_miss_handler.md
DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped one-word lines (power of 2, at least 2).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  load/store request from the backend.
REQ-006 req_ready  output  1  request accepted this cycle when req_valid && req_ready.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-009 req_wdata  input  32  store data.
REQ-010 flush  input  1  invalidate all lines.
REQ-011 data_rdata  output  32  load result, valid only while data_finished1 is high.
REQ-012 data_busy1  output  1  a request is in flight.
REQ-013 data_missed1  output  1  one-cycle pulse on a tag miss.
REQ-014 data_finished1  output  1  one-cycle pulse on request completion.
REQ-015 mem_req, mem_we  output  1 each  memory request and its direction.
REQ-016 mem_addr  output  ADDR_W  memory address; mem_wdata  output  32  memory write data.
REQ-017 mem_ack  input  1; mem_rdata  input  32  memory acknowledge and read data.

Function
REQ-018 States: IDLE, LOOKUP, MEM, DONE; data_busy1 = (state != IDLE).
REQ-019 req_ready = (state == IDLE) && !flush; on acceptance, latch we/addr/wdata and go to LOOKUP.
REQ-020 Index = addr[2 +: log2(LINES)]; tag = the remaining upper address bits; hit = valid[index] && tag match.
REQ-021 LOOKUP, load hit: data_rdata = line data, data_finished1 = 1, next state IDLE (completion one cycle after acceptance).
REQ-022 LOOKUP, load miss: data_missed1 = 1, next state MEM with mem_we = 0.
REQ-023 LOOKUP, store: write-through, no-allocate; on hit update the line data; pulse data_missed1 on miss only; next state MEM with mem_we = 1.
REQ-024 In MEM, mem_req = 1; mem_addr = {addr[ADDR_W-1:2], 2'b00}; mem_wdata = latched wdata; all remain stable until mem_ack.
REQ-025 In MEM with mem_ack, a load writes valid, tag and mem_rdata into the line and captures mem_rdata; next state is DONE.
REQ-026 In DONE, data_finished1 = 1 and data_rdata = captured word (load) or 0 (store); next state is IDLE.
REQ-027 mem_ack outside MEM is ignored; mem_ack may arrive in the first MEM cycle (minimum miss latency is 3 cycles after acceptance).
REQ-028 flush in IDLE clears every valid bit in one cycle and takes priority over a simultaneous req_valid; flush outside IDLE is ignored.
REQ-029 data_missed1 and data_finished1 are never high in the same cycle.

Reset
REQ-030 Reset forces state IDLE and clears all valid bits, even mid-operation.
REQ-031 While reset is high, all outputs read 0: mem_req, data_busy1, data_missed1, data_finished1, data_rdata, req_ready. A pending memory transaction is abandoned.

Configuration
REQ-032 With DCACHE_STATS_EN defined: add outputs hit_count and miss_count (32 bits each). Each counts LOOKUP hits and misses respectively, saturates at 0xFFFFFFFF, and is cleared by reset.
REQ-033 Without DCACHE_STATS_EN: those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-034 Load 0x100 after reset with mem_ack 2 cycles after mem_req and mem_rdata = 0xDEADBEEF -> data_missed1 pulse, then data_finished1 with data_rdata = 0xDEADBEEF.
REQ-035 Repeat load 0x100 -> no mem_req; data_finished1 one cycle after acceptance with 0xDEADBEEF.
REQ-036 Store 0x100 = 0x12345678 followed by load 0x100 -> one mem write (mem_we = 1, mem_addr = 0x100); the load hits and returns 0x12345678.
REQ-037 Load 0x140 with LINES = 16 (same index as 0x100, different tag) -> miss, refill; a subsequent load 0x100 misses again.
REQ-038 flush together with req_valid in IDLE -> req_ready = 0; the next load 0x140 misses.
REQ-039 Assert reset while in MEM -> mem_req drops immediately; after reset, load 0x100 misses. With DCACHE_STATS_EN: hit_count = 0 and miss_count = 0 immediately after reset.
